apb_req_arbiter: RTL

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_arb_pkg.sv | 32 +++
 rtl/apb_rr_picker.sv | 35 +++
 rtl/apb_req_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_arb_pkg                                                   |
// | Brief    : Shared types and sizes for the 4-requester APB arbiter.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package apb_arb_pkg;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int PTR_W  = 2;
  localparam int TO_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } arb_state_e;

  // Pointer position just after the owner of a one-hot grant (wraps mod NREQ)
  function automatic logic [PTR_W-1:0] next_ptr(input logic [NREQ-1:0] onehot);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (onehot[k]) idx = idx | PTR_W'(k);
    end
    return idx + PTR_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_rr_picker                                                 |
// | Brief    : Combinational round-robin pick: first set request found when  |
// |            scanning ptr, ptr+1, ... (mod NREQ).                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module apb_rr_picker
  import apb_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic             valid_o
);

  // Scan from the pointer and keep the first active requester
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             found;
    grant_o = '0;
    found   = 1'b0;
    idx     = ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_i + PTR_W'(k);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_req_arbiter                                               |
// | Brief    : Round-robin arbiter letting 4 requesters share one APB        |
// |            completer. IDLE(arbitrate) -> SETUP -> ACCESS per transfer.   |
// |            Optional ACCESS timeout with APB_ARB_TIMEOUT_EN defined.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [ADDR_W-1:0]        paddr,
  output logic [DATA_W-1:0]        pwdata,
  input  logic                     pready,
  input  logic [DATA_W-1:0]        prdata
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be within 2..255");
  end

  arb_state_e       state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [NREQ-1:0]  gnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic             pwrite_q;

  logic [NREQ-1:0]  pick_gnt;
  logic             pick_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic             sel_write;
  logic             xfer_end;

  apb_rr_picker u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_gnt),
    .valid_o (pick_valid)
  );

  // Route the winning requester's address, data and direction to the latch inputs
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_gnt[k]) begin
        sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[k*DATA_W +: DATA_W];
        sel_write = req_write[k];
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;
  logic            to_hit;

  // Counter reads TIMEOUT_CYC-1 on the last allowed ACCESS cycle
  assign to_hit   = (state_q == ACCESS) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  // A ready completer wins over an expiring timeout
  assign xfer_end = pready || to_hit;
  assign err      = to_hit && !pready;
`else
  assign xfer_end = pready;
  assign err      = 1'b0;
`endif

  // Arbitration, APB sequencing and result capture
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rdata_q  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q    <= pick_gnt;
            paddr_q  <= sel_addr;
            pwdata_q <= sel_wdata;
            pwrite_q <= sel_write;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          state_q <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (xfer_end) begin
            // Aborted reads must not disturb rdata, so only a real pready captures
            if (pready && !pwrite_q) rdata_q <= prdata;
            ptr_q   <= next_ptr(gnt_q);
            gnt_q   <= '0;
            state_q <= IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);
  assign done    = (state_q == ACCESS && xfer_end) ? gnt_q : '0;
  assign gnt     = gnt_q;
  assign rdata   = rdata_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pwrite  = pwrite_q;

endmodule
`default_nettype wire
